// File: rtl/serout_control.sv
// Serial-output sequencer for the POKEY SEROUT path: tracks the holding register,
// counts bit periods and issues registered load/shift strobes to the shifter.
module serout_control #(
    parameter int BITS_PER_FRAME = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic bit_tick,
    input  logic wr_serout,
    input  logic sk_reset,
    output logic load,
    output logic shift,
    output logic seror_pulse,
    output logic seroc,
    output logic busy,
    output logic hold_full
);

    // state    | meaning
    // IDLE     | no frame in progress, waiting for a tick with a byte pending
    // SHIFTING | frame active, bit_cnt_q counts shifts done (0..LAST_CNT)
    typedef enum logic [0:0] {
        IDLE     = 1'b0,
        SHIFTING = 1'b1
    } state_t;

    localparam logic [3:0] LAST_CNT = 4'(BITS_PER_FRAME - 1);

    state_t     state_q;
    logic [3:0] bit_cnt_q;
    logic       load_q;
    logic       shift_q;
    logic       seror_q;
    logic       seroc_q;
    logic       busy_q;
    logic       hold_full_q;

    always_ff @(posedge clk) begin
        if (!rst_n || sk_reset) begin
            state_q     <= IDLE;
            bit_cnt_q   <= 4'd0;
            load_q      <= 1'b0;
            shift_q     <= 1'b0;
            seror_q     <= 1'b0;
            seroc_q     <= 1'b0;
            busy_q      <= 1'b0;
            hold_full_q <= 1'b0;
        end else begin
            load_q  <= 1'b0;
            shift_q <= 1'b0;
            seror_q <= 1'b0;
            if (wr_serout) begin
                hold_full_q <= 1'b1;
                seroc_q     <= 1'b0;
            end
            if (bit_tick) begin
                unique case (state_q)
                    IDLE: begin
                        if (hold_full_q) begin
                            load_q      <= 1'b1;
                            seror_q     <= 1'b1;
                            // a coincident write refills the register just emptied
                            hold_full_q <= wr_serout;
                            bit_cnt_q   <= 4'd0;
                            busy_q      <= 1'b1;
                            state_q     <= SHIFTING;
                        end
                    end
                    SHIFTING: begin
                        if (bit_cnt_q < LAST_CNT) begin
                            shift_q   <= 1'b1;
                            bit_cnt_q <= bit_cnt_q + 4'd1;
                        end else if (hold_full_q) begin
                            load_q      <= 1'b1;
                            seror_q     <= 1'b1;
                            hold_full_q <= wr_serout;
                            bit_cnt_q   <= 4'd0;
                        end else begin
                            state_q <= IDLE;
                            busy_q  <= 1'b0;
                            if (!wr_serout) begin
                                seroc_q <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign load        = load_q;
    assign shift       = shift_q;
    assign seror_pulse = seror_q;
    assign seroc       = seroc_q;
    assign busy        = busy_q;
    assign hold_full   = hold_full_q;

endmodule

// File: tb/tb_serout_control.sv
// Bench for serout_control: directed scenarios plus random traffic, each cycle
// compared against a frame-level reference model.
module tb_serout_control;

    logic clk = 1'b0;
    logic rst_n, bit_tick, wr_serout, sk_reset;
    logic load, shift, seror_pulse, seroc, busy, hold_full;

    int checks = 0;
    int errors = 0;
    int n_load, n_shift, n_seror;

    // reference model: a frame is 1 load tick followed by 9 shift ticks,
    // the 10th tick after a load ends the frame
    bit m_hold, m_seroc, m_in_frame;
    int m_ticks_since_load;
    bit e_load, e_shift;

    serout_control dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bit_tick   (bit_tick),
        .wr_serout  (wr_serout),
        .sk_reset   (sk_reset),
        .load       (load),
        .shift      (shift),
        .seror_pulse(seror_pulse),
        .seroc      (seroc),
        .busy       (busy),
        .hold_full  (hold_full)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input int got, input int exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic model(input bit t, input bit w, input bit s, input bit r);
        bit start_frame;
        e_load  = 0;
        e_shift = 0;
        if (r || s) begin
            m_hold = 0; m_seroc = 0; m_in_frame = 0; m_ticks_since_load = 0;
            return;
        end
        start_frame = 0;
        if (t) begin
            if (!m_in_frame) begin
                start_frame = m_hold;
            end else if (m_ticks_since_load < 10) begin
                e_shift = 1;
                m_ticks_since_load++;
            end else if (m_hold) begin
                start_frame = 1;
            end else begin
                m_in_frame = 0;
                m_seroc = 1;
            end
        end
        if (start_frame) begin
            e_load = 1;
            m_hold = 0;
            m_in_frame = 1;
            m_ticks_since_load = 1;
        end
        // a write lands after the consume/complete decision of the same edge
        if (w) begin
            m_hold = 1;
            m_seroc = 0;
        end
    endtask

    task automatic cyc(input bit t, input bit w, input bit s, input bit r);
        bit_tick  = t;
        wr_serout = w;
        sk_reset  = s;
        rst_n     = !r;
        model(t, w, s, r);
        @(posedge clk);
        #1;
        chk("load", load, e_load);
        chk("shift", shift, e_shift);
        chk("seror_pulse", seror_pulse, e_load);
        chk("seroc", seroc, m_seroc);
        chk("busy", busy, m_in_frame);
        chk("hold_full", hold_full, m_hold);
        n_load  += load;
        n_shift += shift;
        n_seror += seror_pulse;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) begin
            cyc(1, 0, 0, 0);
            cyc(0, 0, 0, 0);
        end
    endtask

    task automatic clr_counts();
        n_load = 0; n_shift = 0; n_seror = 0;
    endtask

    initial begin
        clr_counts();
        cyc(0, 0, 0, 1);
        cyc(1, 1, 0, 1);
        cyc(0, 0, 0, 0);
        chk("reset_seroc", seroc, 0);

        // idle ticks with nothing written
        ticks(5);
        chk("idle_loads", n_load + n_shift + n_seror, 0);

        // single byte
        clr_counts();
        cyc(0, 1, 0, 0);
        ticks(10);
        chk("single_loads", n_load, 1);
        chk("single_shifts", n_shift, 9);
        chk("single_busy_before_end", busy, 1);
        ticks(1);
        chk("single_seroc", seroc, 1);
        chk("single_busy", busy, 0);

        // back-to-back: second write while shift 3 is on the wire
        clr_counts();
        cyc(0, 1, 0, 0);
        ticks(4);
        cyc(0, 1, 0, 0);
        ticks(6);
        cyc(1, 0, 0, 0);
        chk("b2b_tick11_load", load, 1);
        chk("b2b_tick11_seroc", seroc, 0);
        cyc(0, 0, 0, 0);
        ticks(10);
        chk("b2b_shifts", n_shift, 18);
        chk("b2b_serors", n_seror, 2);
        chk("b2b_seroc", seroc, 1);

        // write coincident with a frame-end tick
        clr_counts();
        cyc(0, 1, 0, 0);
        ticks(10);
        cyc(1, 1, 0, 0);
        chk("coend_hold", hold_full, 1);
        chk("coend_seroc", seroc, 0);
        cyc(0, 0, 0, 0);
        cyc(1, 0, 0, 0);
        chk("coend_next_load", load, 1);
        cyc(0, 0, 0, 0);
        ticks(10);

        // write coincident with a load
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        chk("coload_load", load, 1);
        chk("coload_hold", hold_full, 1);
        cyc(0, 0, 0, 0);
        ticks(20);
        chk("coload_seroc", seroc, 1);

        // serial reset after shift 4
        clr_counts();
        cyc(0, 1, 0, 0);
        ticks(5);
        cyc(0, 0, 1, 0);
        chk("skr_busy", busy, 0);
        chk("skr_hold", hold_full, 0);
        clr_counts();
        ticks(12);
        chk("skr_strobes", n_load + n_shift + n_seror, 0);
        chk("skr_seroc", seroc, 0);

        // overwrite before any tick
        clr_counts();
        cyc(0, 1, 0, 0);
        cyc(0, 1, 0, 0);
        ticks(11);
        chk("ovw_loads", n_load, 1);
        chk("ovw_serors", n_seror, 1);
        chk("ovw_seroc", seroc, 1);

        // random traffic, including dense ticks and occasional resets
        for (int i = 0; i < 4000; i++) begin
            cyc(($urandom_range(0, 2) != 0),
                ($urandom_range(0, 24) == 0),
                ($urandom_range(0, 400) == 0),
                ($urandom_range(0, 700) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
